mi_pipe_ext: RTL and testbench

- Parametrised successor of the single-stage MI pipe.
- Inserts a configurable number of request-path stages (skid-buffered, registered ARDY) and response-path register stages between an MI master and an MI slave.
- Adds an outstanding-read limiter and detection of unexpected read responses.
- Sits on MI interconnect links wherever timing closure needs more than one register slice (e.g. across SLR/chiplet boundaries).

---
 rtl/mi_pipe_ext_pkg.sv | 30 +++
 rtl/mi_skid_stage.sv | 59 +++++
 rtl/mi_pipe_ext.sv | 176 +++++++++++++++++
 tb/tb_mi_pipe_ext.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mi_pipe_ext_pkg.sv
// Shared types and helpers for the multi-stage MI pipe.
package mi_pipe_ext_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_META_WIDTH = 2;

  // MI request bundle at the default link geometry; the top re-declares the
  // same layout at its own parameterised widths.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]   dwr;
    logic [DEF_META_WIDTH-1:0]   mwr;
    logic [DEF_ADDR_WIDTH-1:0]   addr;
    logic [DEF_DATA_WIDTH/8-1:0] be;
    logic                        rd;
    logic                        wr;
  } mi_req_t;

  // MI read response bundle at the default link geometry.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] drd;
    logic                      drdy;
  } mi_rsp_t;

  // Width of a counter that must hold 0..max_reads inclusive.
  function automatic int unsigned rd_cnt_width(input int unsigned max_reads);
    return $clog2(max_reads + 1);
  endfunction

endpackage

// File: rtl/mi_skid_stage.sv
// One request-path register slice: a 2-entry skid buffer (main + aux).
// The upstream ready is the aux-empty flag, so it is a pure register output
// and breaks the ready path between neighbouring stages.
module mi_skid_stage
  import mi_pipe_ext_pkg::*;
#(
  parameter type T = mi_req_t
) (
  input  logic clk,
  input  logic reset,
  input  logic up_valid,
  output logic up_ready,
  input  T     up_data,
  output logic dn_valid,
  input  logic dn_ready,
  output T     dn_data
);

  logic main_vld;
  logic aux_vld;
  T     main_q;
  T     aux_q;
  logic push;
  logic pop;
  logic load_main;

  assign up_ready  = ~aux_vld;
  assign push      = up_valid & ~aux_vld;
  assign pop       = main_vld & dn_ready;
  // main is refilled whenever it empties or is consumed; aux only ever holds
  // the one word that arrived while main was stalled
  assign load_main = pop | ~main_vld;

  assign dn_valid = main_vld;
  assign dn_data  = main_q;

  // occupancy flags
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      aux_vld  <= 1'b0;
    end else if (load_main) begin
      main_vld <= aux_vld | push;
      aux_vld  <= 1'b0;
    end else if (push) begin
      aux_vld <= 1'b1;
    end
  end

  // payload registers, intentionally left without reset
  always_ff @(posedge clk) begin
    if (load_main) begin
      main_q <= aux_vld ? aux_q : up_data;
    end else if (push) begin
      aux_q <= up_data;
    end
  end

endmodule

// File: rtl/mi_pipe_ext.sv
// Multi-stage MI pipe: skid-buffered request path, registered response path,
// outstanding-read limiter and unexpected-response detection.
module mi_pipe_ext
  import mi_pipe_ext_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned META_WIDTH = 2,
  parameter int unsigned REQ_STAGES = 2,
  parameter int unsigned RSP_STAGES = 1,
  parameter int unsigned MAX_READS  = 16,
  localparam int unsigned MW = (META_WIDTH > 0) ? META_WIDTH : 1,
  localparam int unsigned CW = rd_cnt_width(MAX_READS)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [DATA_WIDTH-1:0]   IN_DWR,
  input  logic [MW-1:0]           IN_MWR,
  input  logic [ADDR_WIDTH-1:0]   IN_ADDR,
  input  logic [DATA_WIDTH/8-1:0] IN_BE,
  input  logic                    IN_RD,
  input  logic                    IN_WR,
  output logic                    IN_ARDY,
  output logic [DATA_WIDTH-1:0]   IN_DRD,
  output logic                    IN_DRDY,
  output logic [DATA_WIDTH-1:0]   OUT_DWR,
  output logic [MW-1:0]           OUT_MWR,
  output logic [ADDR_WIDTH-1:0]   OUT_ADDR,
  output logic [DATA_WIDTH/8-1:0] OUT_BE,
  output logic                    OUT_RD,
  output logic                    OUT_WR,
  input  logic                    OUT_ARDY,
  input  logic [DATA_WIDTH-1:0]   OUT_DRD,
  input  logic                    OUT_DRDY,
  output logic                    ERR_UNEXP,
  output logic [CW-1:0]           RD_PENDING
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   dwr;
    logic [MW-1:0]           mwr;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    rd;
    logic                    wr;
  } req_t;

  logic [CW-1:0] rd_cnt;
  logic          rd_block;
  logic          rd_xfer;
  logic          rsp_hit;
  logic          rsp_unexp;
  logic          req_valid;
  logic          stage0_ready;
  logic          out_valid;
  req_t          in_req;
  req_t          out_req;

  // limiter uses the registered count only, so a same-cycle response cannot
  // release a blocked read
  assign rd_block  = (rd_cnt == CW'(MAX_READS));
  assign rsp_unexp = OUT_DRDY & (rd_cnt == '0);
  assign rsp_hit   = OUT_DRDY & (rd_cnt != '0);

  // request bundle; a read wins if both strobes are set
  always_comb begin
    in_req      = '0;
    in_req.dwr  = IN_DWR;
    in_req.mwr  = (META_WIDTH > 0) ? IN_MWR : '0;
    in_req.addr = IN_ADDR;
    in_req.be   = IN_BE;
    in_req.rd   = IN_RD;
    in_req.wr   = IN_WR & ~IN_RD;
  end

  assign req_valid = IN_RD ? ~rd_block : IN_WR;
  assign IN_ARDY   = ~RESET & stage0_ready & ~(IN_RD & rd_block);
  assign rd_xfer   = IN_RD & IN_ARDY;

  generate
    if (REQ_STAGES == 0) begin : g_req_bypass
      assign stage0_ready = OUT_ARDY;
      assign out_valid    = req_valid;
      assign out_req      = in_req;
    end else begin : g_req_chain
      req_t                chain_data  [REQ_STAGES+1];
      logic [REQ_STAGES:0] chain_valid;
      logic [REQ_STAGES:0] chain_ready;

      assign chain_data[0]           = in_req;
      assign chain_valid[0]          = req_valid;
      assign stage0_ready            = chain_ready[0];
      assign chain_ready[REQ_STAGES] = OUT_ARDY;
      assign out_valid               = chain_valid[REQ_STAGES];
      assign out_req                 = chain_data[REQ_STAGES];

      for (genvar i = 0; i < REQ_STAGES; i++) begin : g_stage
        mi_skid_stage #(
          .T(req_t)
        ) u_stage (
          .clk     (CLK),
          .reset   (RESET),
          .up_valid(chain_valid[i]),
          .up_ready(chain_ready[i]),
          .up_data (chain_data[i]),
          .dn_valid(chain_valid[i+1]),
          .dn_ready(chain_ready[i+1]),
          .dn_data (chain_data[i+1])
        );
      end
    end
  endgenerate

  assign OUT_DWR  = out_req.dwr;
  assign OUT_MWR  = (META_WIDTH > 0) ? out_req.mwr : '0;
  assign OUT_ADDR = out_req.addr;
  assign OUT_BE   = out_req.be;
  assign OUT_RD   = out_valid & out_req.rd;
  assign OUT_WR   = out_valid & out_req.wr;

  // outstanding-read counter; increment and decrement together cancel
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_cnt <= '0;
    end else if (rd_xfer & ~rsp_hit) begin
      rd_cnt <= rd_cnt + CW'(1);
    end else if (~rd_xfer & rsp_hit) begin
      rd_cnt <= rd_cnt - CW'(1);
    end
  end

  assign RD_PENDING = rd_cnt;

  // one-cycle flag for a response that had no read to answer
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ERR_UNEXP <= 1'b0;
    end else begin
      ERR_UNEXP <= rsp_unexp;
    end
  end

  generate
    if (RSP_STAGES == 0) begin : g_rsp_bypass
      assign IN_DRD  = OUT_DRD;
      assign IN_DRDY = rsp_hit;
    end else begin : g_rsp_pipe
      logic [RSP_STAGES-1:0] rsp_vld;
      logic [DATA_WIDTH-1:0] rsp_data [RSP_STAGES];

      // response valid shift chain; unexpected responses never enter it
      always_ff @(posedge CLK) begin
        if (RESET) begin
          rsp_vld <= '0;
        end else begin
          rsp_vld[0] <= rsp_hit;
          for (int unsigned i = 1; i < RSP_STAGES; i++) begin
            rsp_vld[i] <= rsp_vld[i-1];
          end
        end
      end

      // response data shift chain, no reset
      always_ff @(posedge CLK) begin
        rsp_data[0] <= OUT_DRD;
        for (int unsigned i = 1; i < RSP_STAGES; i++) begin
          rsp_data[i] <= rsp_data[i-1];
        end
      end

      assign IN_DRD  = rsp_data[RSP_STAGES-1];
      assign IN_DRDY = rsp_vld[RSP_STAGES-1];
    end
  endgenerate

endmodule

// File: tb/tb_mi_pipe_ext.sv
// Directed self-checking bench for mi_pipe_ext at REQ_STAGES=2, RSP_STAGES=1,
// MAX_READS=16.
module tb_mi_pipe_ext;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IN_DWR, IN_ADDR, IN_DRD, OUT_DWR, OUT_ADDR, OUT_DRD;
  logic [1:0]  IN_MWR, OUT_MWR;
  logic [3:0]  IN_BE, OUT_BE;
  logic        IN_RD, IN_WR, IN_ARDY, IN_DRDY;
  logic        OUT_RD, OUT_WR, OUT_ARDY, OUT_DRDY, ERR_UNEXP;
  logic [4:0]  RD_PENDING;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          cyc   = 0;
  logic        tog_en = 1'b0;

  logic [71:0] out_q [$];
  int          out_t [$];
  logic [71:0] exp_q [$];

  mi_pipe_ext #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .META_WIDTH(2),
    .REQ_STAGES(2),
    .RSP_STAGES(1),
    .MAX_READS (16)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_DWR    (IN_DWR),
    .IN_MWR    (IN_MWR),
    .IN_ADDR   (IN_ADDR),
    .IN_BE     (IN_BE),
    .IN_RD     (IN_RD),
    .IN_WR     (IN_WR),
    .IN_ARDY   (IN_ARDY),
    .IN_DRD    (IN_DRD),
    .IN_DRDY   (IN_DRDY),
    .OUT_DWR   (OUT_DWR),
    .OUT_MWR   (OUT_MWR),
    .OUT_ADDR  (OUT_ADDR),
    .OUT_BE    (OUT_BE),
    .OUT_RD    (OUT_RD),
    .OUT_WR    (OUT_WR),
    .OUT_ARDY  (OUT_ARDY),
    .OUT_DRD   (OUT_DRD),
    .OUT_DRDY  (OUT_DRDY),
    .ERR_UNEXP (ERR_UNEXP),
    .RD_PENDING(RD_PENDING)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // slave-side transfer log, sampled mid-cycle
  always @(negedge CLK) begin
    if (!RESET && (OUT_RD || OUT_WR) && OUT_ARDY) begin
      out_q.push_back({OUT_DWR, OUT_MWR, OUT_ADDR, OUT_BE, OUT_RD, OUT_WR});
      out_t.push_back(cyc);
    end
  end

  // master must never raise both strobes
  always @(negedge CLK) begin
    assert (!(IN_RD && IN_WR)) else begin
      bad++;
      $error("FAIL rd_wr_exclusive observed=both expected=one");
    end
  end

  // slave ready toggles 1010... while enabled
  initial forever begin
    @(posedge CLK);
    #1;
    if (tog_en) OUT_ARDY = ~OUT_ARDY;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack_req(input logic rd, input logic wr,
                                           input logic [31:0] addr, input logic [31:0] dwr,
                                           input logic [1:0] mwr, input logic [3:0] be);
    return {dwr, mwr, addr, be, rd, wr};
  endfunction

  function automatic logic [71:0] wvec(input int i);
    return pack_req(1'b0, 1'b1, 32'h1000 + 32'(i) * 4, 32'hA500_0000 + 32'(i),
                    2'(i), 4'(i) | 4'b0001);
  endfunction

  task automatic setv(input logic [71:0] v);
    {IN_DWR, IN_MWR, IN_ADDR, IN_BE, IN_RD, IN_WR} = v;
  endtask

  task automatic idle();
    IN_RD = 1'b0;
    IN_WR = 1'b0;
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  // present a request and hold it until accepted, bounded
  task automatic send(input logic [71:0] v);
    int unsigned n;
    n = 0;
    setv(v);
    #1;
    while (!IN_ARDY && n < 40) begin
      nxt();
      #1;
      n++;
    end
    chk("send_accept", (n < 40), 1'b1);
    nxt();
  endtask

  initial begin
    logic [71:0] v;
    logic        isrd;
    int unsigned nreads;
    int          c0;

    RESET = 1'b1;
    IN_DWR = '0; IN_MWR = '0; IN_ADDR = '0; IN_BE = '0;
    IN_RD = 1'b0; IN_WR = 1'b0;
    OUT_ARDY = 1'b1; OUT_DRD = '0; OUT_DRDY = 1'b0;
    repeat (3) nxt();

    // reset state
    chk("rst_ardy", IN_ARDY, 0);
    chk("rst_out_rd", OUT_RD, 0);
    chk("rst_out_wr", OUT_WR, 0);
    chk("rst_drdy", IN_DRDY, 0);
    chk("rst_err", ERR_UNEXP, 0);
    chk("rst_pending", RD_PENDING, 0);
    RESET = 1'b0;
    #1;
    chk("ardy_after_reset", IN_ARDY, 1);
    nxt();

    // 100 back-to-back writes
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      setv(wvec(i));
      #1;
      chk("t1_ardy", IN_ARDY, 1);
      nxt();
    end
    idle();
    repeat (5) nxt();
    chk("t1_count", out_q.size(), 100);
    for (int i = 0; i < 100 && i < out_q.size(); i++) begin
      chk("t1_data", out_q[i], wvec(i));
      chk("t1_latency", out_t[i] - c0 - i, 2);
    end

    // read limit
    out_q.delete();
    out_t.delete();
    for (int i = 0; i < 16; i++) begin
      setv(pack_req(1'b1, 1'b0, 32'h2000 + 32'(i) * 4, '0, '0, 4'hF));
      #1;
      chk("t2_rd_ardy", IN_ARDY, 1);
      nxt();
    end
    setv(pack_req(1'b1, 1'b0, 32'h3000, '0, '0, 4'hF));
    #1;
    chk("t2_pending_full", RD_PENDING, 16);
    chk("t2_rd_blocked", IN_ARDY, 0);
    nxt();
    setv(pack_req(1'b0, 1'b1, 32'h3100, 32'h77, 2'd1, 4'hF));
    #1;
    chk("t2_wr_at_limit", IN_ARDY, 1);
    nxt();
    setv(pack_req(1'b1, 1'b0, 32'h3000, '0, '0, 4'hF));
    OUT_DRDY = 1'b1;
    OUT_DRD  = 32'h1234_5678;
    #1;
    chk("t2_blocked_same_drdy", IN_ARDY, 0);
    chk("t2_pending_still_full", RD_PENDING, 16);
    nxt();
    OUT_DRDY = 1'b0;
    OUT_DRD  = '0;
    #1;
    chk("t2_rd_unblocked", IN_ARDY, 1);
    chk("t2_pending_15", RD_PENDING, 15);
    chk("t2_rsp_drdy", IN_DRDY, 1);
    chk("t2_rsp_data", IN_DRD, 32'h1234_5678);
    nxt();
    idle();
    #1;
    chk("t2_pending_refull", RD_PENDING, 16);
    chk("t2_drdy_one_cycle", IN_DRDY, 0);
    OUT_DRDY = 1'b1;
    repeat (16) nxt();
    OUT_DRDY = 1'b0;
    #1;
    chk("t2_drained", RD_PENDING, 0);
    chk("t2_out_count", out_q.size(), 18);
    if (out_q.size() == 18) begin
      chk("t2_out_wr", out_q[16], pack_req(1'b0, 1'b1, 32'h3100, 32'h77, 2'd1, 4'hF));
      chk("t2_out_rd17", out_q[17], pack_req(1'b1, 1'b0, 32'h3000, '0, '0, 4'hF));
    end
    nxt();

    // random stream with toggling slave ready
    out_q.delete();
    out_t.delete();
    nreads = 0;
    tog_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      isrd = ($urandom_range(0, 3) == 0) && (nreads < 12);
      v = pack_req(isrd, !isrd, $urandom, $urandom, 2'($urandom), 4'($urandom));
      exp_q.push_back(v);
      if (isrd) nreads++;
      send(v);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        nxt();
      end
    end
    idle();
    repeat (12) nxt();
    tog_en = 1'b0;
    nxt();
    OUT_ARDY = 1'b1;
    chk("t3_count", out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      chk("t3_seq", out_q[i], exp_q[i]);
    end
    chk("t3_pending", RD_PENDING, nreads);
    OUT_DRDY = 1'b1;
    repeat (nreads) nxt();
    OUT_DRDY = 1'b0;
    #1;
    chk("t3_drained", RD_PENDING, 0);
    nxt();

    // read with delayed response
    setv(pack_req(1'b1, 1'b0, 32'h40, '0, '0, 4'hF));
    #1;
    chk("t4_ardy", IN_ARDY, 1);
    nxt();
    idle();
    #1;
    chk("t4_not_yet", OUT_RD, 0);
    nxt();
    chk("t4_out_rd", OUT_RD, 1);
    chk("t4_out_addr", OUT_ADDR, 32'h40);
    repeat (5) nxt();
    OUT_DRDY = 1'b1;
    OUT_DRD  = 32'hCAFE_BABE;
    #1;
    chk("t4_drdy_not_comb", IN_DRDY, 0);
    nxt();
    OUT_DRDY = 1'b0;
    OUT_DRD  = '0;
    #1;
    chk("t4_drdy", IN_DRDY, 1);
    chk("t4_drd", IN_DRD, 32'hCAFE_BABE);
    chk("t4_pending", RD_PENDING, 0);
    nxt();
    chk("t4_drdy_end", IN_DRDY, 0);

    // unexpected response
    OUT_DRDY = 1'b1;
    OUT_DRD  = 32'hDEAD_0001;
    #1;
    chk("t5_err_pre", ERR_UNEXP, 0);
    nxt();
    OUT_DRDY = 1'b0;
    OUT_DRD  = '0;
    #1;
    chk("t5_err", ERR_UNEXP, 1);
    chk("t5_no_fwd", IN_DRDY, 0);
    chk("t5_pending", RD_PENDING, 0);
    nxt();
    chk("t5_err_pulse", ERR_UNEXP, 0);
    chk("t5_no_fwd_late", IN_DRDY, 0);

    // reset mid-operation
    for (int i = 0; i < 4; i++) begin
      setv(pack_req(1'b1, 1'b0, 32'h500 + 32'(i) * 4, '0, '0, 4'hF));
      #1;
      chk("t6_rd_ardy", IN_ARDY, 1);
      nxt();
    end
    idle();
    repeat (3) nxt();
    OUT_ARDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(pack_req(1'b0, 1'b1, 32'h600 + 32'(i) * 4, 32'h6000 + 32'(i), '0, 4'hF));
    end
    idle();
    #1;
    chk("t6_pending", RD_PENDING, 4);
    chk("t6_stalled_wr", OUT_WR, 1);
    RESET = 1'b1;
    nxt();
    chk("t6_rst_out_wr", OUT_WR, 0);
    chk("t6_rst_out_rd", OUT_RD, 0);
    chk("t6_rst_pending", RD_PENDING, 0);
    chk("t6_rst_ardy", IN_ARDY, 0);
    RESET = 1'b0;
    OUT_ARDY = 1'b1;
    out_q.delete();
    out_t.delete();
    #1;
    chk("t6_ardy_after", IN_ARDY, 1);
    nxt();
    setv(pack_req(1'b0, 1'b1, 32'h700, 32'hBEEF_0007, 2'd3, 4'h5));
    nxt();
    idle();
    #1;
    chk("t6_lat1", OUT_WR, 0);
    nxt();
    chk("t6_wr_out", OUT_WR, 1);
    chk("t6_wr_data", {OUT_DWR, OUT_MWR, OUT_ADDR, OUT_BE, OUT_RD, OUT_WR},
        pack_req(1'b0, 1'b1, 32'h700, 32'hBEEF_0007, 2'd3, 4'h5));
    nxt();
    chk("t6_wr_once", OUT_WR, 0);
    chk("t6_out_count", out_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
